// File: rtl/gmi_enid_pipe_bridge_pkg.sv
// Shared types and widths for the GMI -> enid pipelined bridge.
// The guarded defines stand in for gmi_defs.vh / enid_defs.vh when those are not already loaded.
`ifndef GMI_OK
`define GMI_OK 2'b00
`endif
`ifndef GMI_ERR
`define GMI_ERR 2'b01
`endif
`ifndef GMI_ADDR_W
`define GMI_ADDR_W 32
`endif
`ifndef ENID_ADDR_W
`define ENID_ADDR_W 32
`endif
`ifndef ENID_LEN_W
`define ENID_LEN_W 12
`endif
`ifndef ENID_MODULE_ID_W
`define ENID_MODULE_ID_W 4
`endif
`ifndef ENID_SUB_ID_W
`define ENID_SUB_ID_W 2
`endif

package gmi_enid_pipe_bridge_pkg;
  localparam int GMI_ADDR_W       = `GMI_ADDR_W;
  localparam int ENID_ADDR_W      = `ENID_ADDR_W;
  localparam int ENID_LEN_W       = `ENID_LEN_W;
  localparam int ENID_MODULE_ID_W = `ENID_MODULE_ID_W;
  localparam int ENID_SUB_ID_W    = `ENID_SUB_ID_W;

  localparam logic [1:0] ENID_TYPE_MEM = 2'd0;
  localparam logic [1:0] ENID_OP_RD    = 2'd0;
  localparam logic [1:0] ENID_OP_WR    = 2'd1;

  typedef enum logic [1:0] {REQ_IDLE, REQ_HDR, REQ_WDATA} req_st_e;
  typedef enum logic [1:0] {RSP_IDLE, RSP_RDATA, RSP_PRESENT} rsp_st_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/gmi_enid_pend_fifo.sv
// Small synchronous FIFO tracking the kind (read/write) of each accepted access.
module gmi_enid_pend_fifo
  import gmi_enid_pipe_bridge_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = clog2_min1(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [$clog2(DEPTH):0]      cnt_q, cnt_d;
  logic                        do_push, do_pop;

  assign full    = cnt_q == ($clog2(DEPTH)+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign count   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + ($clog2(DEPTH)+1)'(do_push) - ($clog2(DEPTH)+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/gmi_enid_pipe_bridge.sv
// GMI slave -> enid master bridge: splits each GMI access into BEATS enid beats, in-order retire.
// Optional response watchdog with orphan draining: define GMI_ENID_TIMEOUT_EN.
module gmi_enid_pipe_bridge
  import gmi_enid_pipe_bridge_pkg::*;
#(
  parameter int                            ADDR_WIDTH     = `GMI_ADDR_W,
  parameter int                            DATA_WIDTH     = 64,
  parameter int                            EP_DATA_W      = 32,
  parameter logic [`ENID_MODULE_ID_W-1:0]  DEST_MOD       = 4'd1,
  parameter logic [`ENID_SUB_ID_W-1:0]     DEST_SUB       = 2'd0,
  parameter int                            OUTSTANDING    = 4,
  parameter int                            TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_req_valid,
  output logic                          s_req_ready,
  input  logic                          s_req_write,
  input  logic [ADDR_WIDTH-1:0]         s_req_addr,
  input  logic [DATA_WIDTH-1:0]         s_req_wdata,
  output logic                          s_rsp_valid,
  input  logic                          s_rsp_ready,
  output logic [1:0]                    s_rsp_status,
  output logic [DATA_WIDTH-1:0]         s_rsp_rdata,
  output logic                          req_valid,
  input  logic                          req_ready,
  output logic [1:0]                    req_type,
  output logic [1:0]                    req_mem_op,
  output logic [`ENID_MODULE_ID_W-1:0]  req_dest_mod,
  output logic [`ENID_SUB_ID_W-1:0]     req_dest_sub,
  output logic [`ENID_ADDR_W-1:0]       req_addr,
  output logic [`ENID_LEN_W-1:0]        req_len,
  output logic                          req_wvalid,
  input  logic                          req_wready,
  output logic [EP_DATA_W-1:0]          req_wdata,
  output logic                          req_wlast,
  input  logic                          rsp_valid,
  output logic                          rsp_ready,
  input  logic [1:0]                    rsp_status,
  input  logic [`ENID_LEN_W-1:0]        rsp_len,
  input  logic                          rsp_rvalid,
  output logic                          rsp_rready,
  input  logic [EP_DATA_W-1:0]          rsp_rdata,
  input  logic                          rsp_rlast
);
  localparam int BEATS = DATA_WIDTH / EP_DATA_W;
  localparam int BW    = clog2_min1(BEATS);
  localparam int KW    = $clog2(BEATS + 1);
  localparam logic [`ENID_LEN_W-1:0] REQ_LEN = `ENID_LEN_W'(BEATS * EP_DATA_W / 8);

  // ---------------- request side ----------------
  req_st_e                        req_st_q, req_st_d;
  logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
  logic [BEATS-1:0][EP_DATA_W-1:0] wdata_q, wdata_d;
  logic                           wr_q, wr_d;
  logic [BW-1:0]                  wbeat_q, wbeat_d;
  logic                           rdy_en_q, rdy_en_d;
  logic                           accept;

  logic                           pend_full, pend_empty, pend_head_wr, pend_pop;
  logic [$clog2(OUTSTANDING):0]   pend_count;
  logic                           unused_pend_count;

  // rdy_en_q keeps s_req_ready low while reset is asserted.
  assign s_req_ready  = rdy_en_q && (req_st_q == REQ_IDLE) && !pend_full;
  assign accept       = s_req_valid && s_req_ready;
  assign req_valid    = req_st_q == REQ_HDR;
  assign req_type     = ENID_TYPE_MEM;
  assign req_mem_op   = wr_q ? ENID_OP_WR : ENID_OP_RD;
  assign req_dest_mod = DEST_MOD;
  assign req_dest_sub = DEST_SUB;
  assign req_addr     = `ENID_ADDR_W'(addr_q);
  assign req_len      = REQ_LEN;
  assign req_wvalid   = req_st_q == REQ_WDATA;
  assign req_wdata    = wdata_q[wbeat_q];
  assign req_wlast    = req_wvalid && (wbeat_q == BW'(BEATS - 1));
  assign unused_pend_count = ^pend_count;

  always_comb begin
    req_st_d = req_st_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    wbeat_d  = wbeat_q;
    rdy_en_d = 1'b1;
    case (req_st_q)
      REQ_IDLE: if (accept) begin
        addr_d   = s_req_addr;
        wdata_d  = s_req_wdata;
        wr_d     = s_req_write;
        wbeat_d  = '0;
        req_st_d = REQ_HDR;
      end
      REQ_HDR: if (req_ready) req_st_d = wr_q ? REQ_WDATA : REQ_IDLE;
      REQ_WDATA: if (req_wready) begin
        wbeat_d = wbeat_q + 1'b1;
        if (req_wlast) req_st_d = REQ_IDLE;
      end
      default: req_st_d = REQ_IDLE;
    endcase
  end

  gmi_enid_pend_fifo #(.WIDTH(1), .DEPTH(OUTSTANDING)) u_pend (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .din   (s_req_write),
    .pop   (pend_pop),
    .dout  (pend_head_wr),
    .full  (pend_full),
    .empty (pend_empty),
    .count (pend_count)
  );

  // ---------------- response side ----------------
  rsp_st_e                         rsp_st_q, rsp_st_d;
  logic                            err_q, err_d;
  logic [BEATS-1:0][EP_DATA_W-1:0] rdata_q, rdata_d;
  logic [KW-1:0]                   rbeat_q, rbeat_d;
  logic                            drop_q, drop_d;
  logic                            hdr_hs, orph_any, orph_head_wr, tmo_hit;

  assign rsp_ready    = (rsp_st_q == RSP_IDLE) && (!pend_empty || orph_any);
  assign rsp_rready   = rsp_st_q == RSP_RDATA;
  assign hdr_hs       = rsp_valid && rsp_ready;
  assign s_rsp_valid  = rsp_st_q == RSP_PRESENT;
  assign s_rsp_status = err_q ? `GMI_ERR : `GMI_OK;
  assign s_rsp_rdata  = rdata_q;
  assign pend_pop     = s_rsp_valid && s_rsp_ready;

`ifdef GMI_ENID_TIMEOUT_EN
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int OCW = $clog2(OUTSTANDING + 1);
  localparam int OAW = clog2_min1(OUTSTANDING);

  logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic [OCW-1:0]         orph_cnt_q, orph_cnt_d;
  logic [OUTSTANDING-1:0] orph_wr_q, orph_wr_d;

  assign orph_any     = orph_cnt_q != '0;
  assign orph_head_wr = orph_wr_q[0];

  // Orphans are retired-by-timeout accesses whose late responses must still be consumed.
  always_comb begin
    tmo_cnt_d  = tmo_cnt_q;
    tmo_hit    = 1'b0;
    orph_cnt_d = orph_cnt_q;
    orph_wr_d  = orph_wr_q;
    if (hdr_hs) begin
      tmo_cnt_d = '0;
    end else if (rsp_st_q == RSP_IDLE && !pend_empty) begin
      if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        tmo_hit   = 1'b1;
        tmo_cnt_d = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
    if (hdr_hs && orph_any) begin
      orph_wr_d  = orph_wr_q >> 1;
      orph_cnt_d = orph_cnt_q - 1'b1;
    end else if (tmo_hit && orph_cnt_q != OCW'(OUTSTANDING)) begin
      orph_wr_d[orph_cnt_q[OAW-1:0]] = pend_head_wr;
      orph_cnt_d = orph_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q  <= '0;
      orph_cnt_q <= '0;
      orph_wr_q  <= '0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      orph_cnt_q <= orph_cnt_d;
      orph_wr_q  <= orph_wr_d;
    end
  end
`else
  assign orph_any     = 1'b0;
  assign orph_head_wr = 1'b0;
  assign tmo_hit      = 1'b0;
`endif

  always_comb begin
    rsp_st_d = rsp_st_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    rbeat_d  = rbeat_q;
    drop_d   = drop_q;
    case (rsp_st_q)
      RSP_IDLE: begin
        if (hdr_hs) begin
          rbeat_d = '0;
          if (orph_any) begin
            drop_d   = 1'b1;
            rsp_st_d = orph_head_wr ? RSP_IDLE : RSP_RDATA;
          end else begin
            drop_d   = 1'b0;
            err_d    = (rsp_status != 2'b00) || (rsp_len != REQ_LEN);
            rdata_d  = '0;
            rsp_st_d = pend_head_wr ? RSP_PRESENT : RSP_RDATA;
          end
        end else if (tmo_hit) begin
          err_d    = 1'b1;
          rdata_d  = '0;
          rsp_st_d = RSP_PRESENT;
        end
      end
      RSP_RDATA: if (rsp_rvalid) begin
        if (rbeat_q < KW'(BEATS)) begin
          if (!drop_q) rdata_d[rbeat_q[BW-1:0]] = rsp_rdata;
          rbeat_d = rbeat_q + 1'b1;
        end else if (!drop_q) begin
          err_d = 1'b1;
        end
        if (rsp_rlast) begin
          // Short burst: untouched slices were cleared at header time.
          if (!drop_q && rbeat_q < KW'(BEATS - 1)) err_d = 1'b1;
          rsp_st_d = drop_q ? RSP_IDLE : RSP_PRESENT;
        end
      end
      RSP_PRESENT: if (s_rsp_ready) rsp_st_d = RSP_IDLE;
      default: rsp_st_d = RSP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_st_q <= REQ_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      wbeat_q  <= '0;
      rdy_en_q <= 1'b0;
      rsp_st_q <= RSP_IDLE;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rbeat_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      req_st_q <= req_st_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      wbeat_q  <= wbeat_d;
      rdy_en_q <= rdy_en_d;
      rsp_st_q <= rsp_st_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rbeat_q  <= rbeat_d;
      drop_q   <= drop_d;
    end
  end
endmodule
